mux_stim_sequencer: RTL and testbench

Upstream stimulus-and-check stage for the two-to-one multiplexer. On a start pulse it steps through all 8 input combinations {selection, I[1:0]}. Each vector is held on the mux inputs for a programmable number of cycles, and the mux output is sampled and compared against the expected value. It reports an error count, the first failing vector, and a pass/done indication, giving the team a self-checking hardware harness for the mux.

---
 rtl/mux_test_pkg.sv | 21 ++
 rtl/hold_timer.sv | 37 +++
 rtl/mux_stim_sequencer.sv | 138 +++++++++++++
 tb/tb_mux_stim_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_test_pkg.sv
// rtl/mux_test_pkg.sv - shared constants, state encoding and golden mux function
//
// Purpose: definitions shared by the mux stimulus sequencer and its hold timer.
// Ports:   none (package).
package mux_test_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Golden 2:1 mux: vec[2] is the select, vec[1:0] are the data inputs.
  function automatic logic expected_y(input logic [VEC_W-1:0] vec);
    return vec[2] ? vec[1] : vec[0];
  endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-vector hold counter with terminal-count flag
//
// Purpose: counts cycles a vector has been applied; tc flags HOLD_CYCLES-1.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   clear  in   synchronous clear to 0 (has priority over enable)
//   enable in   count up by one
//   count  out  current hold count
//   tc     out  count == HOLD_CYCLES-1
module hold_timer #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [HOLD_W-1:0] count,
  output logic              tc
);

  localparam logic [HOLD_W-1:0] TC_VAL = HOLD_W'(HOLD_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mux_stim_sequencer.sv
// rtl/mux_stim_sequencer.sv - exhaustive stimulus and checker for a 2:1 mux
//
// Purpose: on start, applies all 8 {sel,I[1:0]} vectors to the mux under test,
//          each for HOLD_CYCLES cycles, checks Y on the last held cycle and
//          reports error count, first failing vector and pass/done.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             run request, honoured only in IDLE
//   mux_y             Y returned by the mux under test
//   mux_i, mux_sel    stimulus driven to the mux
//   busy              high in RUN and DONE
//   done              one-cycle pulse at end of run
//   pass              last completed run had zero errors
//   err_count         mismatches in current/last run
//   first_fail_vec    {sel,I} of first mismatch; first_fail_valid qualifies it
module mux_stim_sequencer
  import mux_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mux_y,
  output logic [1:0]       mux_i,
  output logic             mux_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec, vec_nxt;
  logic [3:0]       err_nxt;
  logic [VEC_W-1:0] ffv_nxt;
  logic             ffvalid_nxt;
  logic             pass_nxt;
  logic             hold_clear;
  logic             hold_en;
  logic             hold_tc;
  logic [HOLD_W-1:0] hold_count;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (hold_clear),
    .enable(hold_en),
    .count (hold_count),
    .tc    (hold_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      vec              <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state            <= state_nxt;
      vec              <= vec_nxt;
      err_count        <= err_nxt;
      first_fail_vec   <= ffv_nxt;
      first_fail_valid <= ffvalid_nxt;
      pass             <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    vec_nxt     = vec;
    err_nxt     = err_count;
    ffv_nxt     = first_fail_vec;
    ffvalid_nxt = first_fail_valid;
    pass_nxt    = pass;
    hold_clear  = 1'b0;
    hold_en     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_RUN;
          vec_nxt     = '0;
          err_nxt     = '0;
          ffv_nxt     = '0;
          ffvalid_nxt = 1'b0;
          pass_nxt    = 1'b0;
          hold_clear  = 1'b1;
        end
      end

      ST_RUN: begin
        hold_en = 1'b1;
        if (hold_tc) begin
          hold_clear = 1'b1;
          if (mux_y != expected_y(vec)) begin
            err_nxt = err_count + 4'd1;
            if (!first_fail_valid) begin
              ffv_nxt     = vec;
              ffvalid_nxt = 1'b1;
            end
          end
          if (vec == LAST_VEC) begin
            state_nxt = ST_DONE;
            // Uses err_nxt so a mismatch on the final vector is reflected.
            pass_nxt  = (err_nxt == 4'd0);
          end else begin
            vec_nxt = vec + VEC_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mux_sel = (state == ST_RUN) ? vec[2]   : 1'b0;
  assign mux_i   = (state == ST_RUN) ? vec[1:0] : 2'b00;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// tb/tb_mux_stim_sequencer.sv - scoreboard bench for mux_stim_sequencer
module tb_mux_stim_sequencer;

  typedef struct packed {
    logic [3:0] err;
    logic       ffvalid;
    logic [2:0] ffv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // HOLD_CYCLES=4 instance with a combinational mux model
  logic       start4 = 1'b0;
  logic       y4;
  logic [1:0] i4;
  logic       sel4, busy4, done4, pass4, ffvalid4;
  logic [3:0] err4;
  logic [2:0] ffv4;
  int         mode4 = 0;  // 0 correct, 1 stuck-at-0, 2 inverted

  // HOLD_CYCLES=2 instance with a one-cycle registered mux model
  logic       start2 = 1'b0;
  logic       y2 = 1'b0;
  logic [1:0] i2;
  logic       sel2, busy2, done2, pass2, ffvalid2;
  logic [3:0] err2;
  logic [2:0] ffv2;

  mux_stim_sequencer #(.HOLD_CYCLES(4), .HOLD_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mux_y(y4),
    .mux_i(i4), .mux_sel(sel4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail_vec(ffv4), .first_fail_valid(ffvalid4)
  );

  mux_stim_sequencer #(.HOLD_CYCLES(2), .HOLD_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mux_y(y2),
    .mux_i(i2), .mux_sel(sel2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
  );

  always_comb begin
    y4 = sel4 ? i4[1] : i4[0];
    if (mode4 == 1) y4 = 1'b0;
    else if (mode4 == 2) y4 = ~(sel4 ? i4[1] : i4[0]);
  end

  always @(posedge clk) y2 <= sel2 ? i2[1] : i2[0];

  int   total = 0;
  int   passed = 0;
  int   done_cnt4 = 0;
  int   done_cnt2 = 0;
  exp_t q4[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Scoreboard monitors: compare run results whenever done is presented.
  always @(negedge clk) begin
    if (done4) begin
      exp_t e;
      done_cnt4++;
      if (q4.size() == 0) begin
        check("dut4 unexpected done", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("dut4 err_count", 32'(err4), 32'(e.err));
        check("dut4 first_fail", 32'({ffvalid4, ffv4}), 32'({e.ffvalid, e.ffv}));
        check("dut4 pass", 32'(pass4), 32'(e.pass));
      end
    end
    if (done2) begin
      exp_t e;
      done_cnt2++;
      if (q2.size() == 0) begin
        check("dut2 unexpected done", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("dut2 err_count", 32'(err2), 32'(e.err));
        check("dut2 first_fail", 32'({ffvalid2, ffv2}), 32'({e.ffvalid, e.ffv}));
        check("dut2 pass", 32'(pass2), 32'(e.pass));
      end
    end
  end

  function automatic logic [5:0] snap(input bit use2);
    return use2 ? {busy2, done2, 1'b0, sel2, i2} : {busy4, done4, 1'b0, sel4, i4};
  endfunction

  // Issues a start pulse and returns #1 after the accepting edge.
  task automatic start_run(input bit use2);
    @(negedge clk);
    if (use2) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    if (use2) start2 = 1'b0; else start4 = 1'b0;
    if (!use2) check("run cleared on start", 32'({err4, ffvalid4, pass4}), 32'd0);
  endtask

  // Called #1 after the accepting edge; checks the vector sequence, the done
  // pulse 8*hold edges later, and leaves the caller #1 after that edge.
  task automatic check_run(input bit use2, input int hold);
    for (int c = 0; c < 8 * hold; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check("run vector", 32'(snap(use2)), 32'({3'b100, 3'(c / hold)}));
    end
    @(posedge clk);
    #1;
    check("done cycle", 32'(snap(use2)), 32'({3'b110, 3'b000}));
  endtask

  initial begin
    #12;
    check("reset outputs", 32'({sel4, i4, busy4, done4, pass4, err4, ffv4, ffvalid4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: correct mux
    mode4 = 0;
    q4.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    start_run(1'b0);
    check_run(1'b0, 4);
    @(posedge clk);
    #1;
    check("back to idle", 32'({busy4, done4}), 32'd0);

    // 2: stuck-at-0 -> vectors 1,3,6,7 fail
    mode4 = 1;
    q4.push_back('{err: 4'd4, ffvalid: 1'b1, ffv: 3'b001, pass: 1'b0});
    start_run(1'b0);
    check_run(1'b0, 4);

    // 3: inverted mux then a correct run
    repeat (2) @(posedge clk);
    mode4 = 2;
    q4.push_back('{err: 4'd8, ffvalid: 1'b1, ffv: 3'b000, pass: 1'b0});
    start_run(1'b0);
    check_run(1'b0, 4);
    @(posedge clk);
    #1;
    check("pass held after run", 32'({pass4, err4}), 32'({1'b0, 4'd8}));
    mode4 = 0;
    q4.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    start_run(1'b0);
    check_run(1'b0, 4);

    // 4: start re-pulsed mid-run and held through DONE
    repeat (2) @(posedge clk);
    q4.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    q4.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    start_run(1'b0);
    fork
      begin
        repeat (4) @(posedge clk);
        #2 start4 = 1'b1;
        @(posedge clk);
        #2 start4 = 1'b0;
        repeat (14) @(posedge clk);
        #2 start4 = 1'b1;
      end
      check_run(1'b0, 4);
    join
    @(posedge clk);
    #1;
    check("idle cycle after done", 32'({busy4, done4}), 32'd0);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check_run(1'b0, 4);

    // 6: HOLD_CYCLES=2 with a registered mux
    repeat (2) @(posedge clk);
    q2.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    start_run(1'b1);
    check_run(1'b1, 2);

    // 5: async reset while vec=4 during an inverted run
    repeat (2) @(posedge clk);
    mode4 = 2;
    start_run(1'b0);
    repeat (16) @(posedge clk);
    #1;
    check("mid-run vec4 errors", 32'({sel4, i4, err4}), 32'({3'b100, 4'd4}));
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", 32'({sel4, i4, busy4, done4, pass4, err4, ffv4, ffvalid4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle after reset", 32'({busy4, done4}), 32'd0);
    mode4 = 0;
    q4.push_back('{err: 4'd0, ffvalid: 1'b0, ffv: 3'd0, pass: 1'b1});
    start_run(1'b0);
    check_run(1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    check("dut4 done pulses", 32'(done_cnt4), 32'd7);
    check("dut2 done pulses", 32'(done_cnt2), 32'd1);
    check("scoreboard drained", 32'(q4.size() + q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
